// File: rtl/simd_result_collector.sv
// simd_result_collector: captures SIMD ALU results into a small FIFO and streams them as 64-bit beats.
// Optional macro SIMD_RC_EXTRA_EN: also carry extra_result words (128-bit entries, two beats each).
module simd_result_collector #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        batch_start,
  input  logic [5:0]  batch_len,
  input  logic        procc_done,
  input  logic [31:0] res_procc0,
  input  logic [31:0] res_extra0,
  input  logic [31:0] res_procc1,
  input  logic [31:0] res_extra1,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        batch_busy,
  output logic        batch_done,
  output logic        overflow,
  output logic        stray
);

`ifdef SIMD_RC_EXTRA_EN
  localparam int EW = 128;
`else
  localparam int EW = 64;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t        state_reg, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [5:0]    len_reg, len_next;
  logic [5:0]    cnt_reg, cnt_next;
  logic          done_q_reg;
  logic          overflow_reg, overflow_next;
  logic          stray_reg, stray_next;
  logic          cap, push_req, push_ok, pop, full, start_ok;

  assign cap      = procc_done & ~done_q_reg;
  assign push_req = cap & (state_reg == COLLECT);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign rd_valid = (count_reg != '0);
  // A full FIFO still accepts when the head entry leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);
  assign head     = mem[rd_ptr_reg];

`ifdef SIMD_RC_EXTRA_EN
  logic beat_reg, beat_next;

  assign wr_entry = {res_procc0, res_procc1, res_extra0, res_extra1};
  assign pop      = rd_valid & rd_ready & beat_reg;
  assign rd_data  = !rd_valid ? '0 : (beat_reg ? head[63:0] : head[127:64]);

  always_comb begin
    beat_next = beat_reg;
    if (rd_valid & rd_ready)
      beat_next = ~beat_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      beat_reg <= 1'b0;
    else
      beat_reg <= beat_next;
  end
`else
  logic unused_extra;

  assign unused_extra = ^{res_extra0, res_extra1};
  assign wr_entry     = {res_procc0, res_procc1};
  assign pop          = rd_valid & rd_ready;
  assign rd_data      = rd_valid ? head : '0;
`endif

  // Small FIFO: asynchronous read so a fresh entry is visible the cycle after capture.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wr_entry;
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    start_ok   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (batch_start) begin
          start_ok   = 1'b1;
          len_next   = batch_len;
          cnt_next   = '0;
          state_next = (batch_len == '0) ? FLUSH : COLLECT;
        end
      end
      COLLECT: begin
        if (push_ok) begin
          cnt_next = cnt_reg + 6'd1;
          if (cnt_next == len_reg)
            state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (count_reg == '0)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stickies clear on an accepted start; a same-cycle event still sets them.
  always_comb begin
    overflow_next = overflow_reg;
    stray_next    = stray_reg;
    if (start_ok) begin
      overflow_next = 1'b0;
      stray_next    = 1'b0;
    end
    if (push_req & ~push_ok)
      overflow_next = 1'b1;
    if (cap & (state_reg != COLLECT))
      stray_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      done_q_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      stray_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      done_q_reg   <= procc_done;
      overflow_reg <= overflow_next;
      stray_reg    <= stray_next;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign batch_busy = (state_reg != IDLE);
  assign batch_done = (state_reg == DONE);
  assign overflow   = overflow_reg;
  assign stray      = stray_reg;

endmodule

// File: tb/tb_simd_result_collector.sv
// Directed, self-checking bench for simd_result_collector (table vectors plus multi-cycle corner cases).
// Follows the SIMD_RC_EXTRA_EN build setting for the number of beats per entry.
module tb_simd_result_collector;

`ifdef SIMD_RC_EXTRA_EN
  localparam int BEATS = 2;
`else
  localparam int BEATS = 1;
`endif
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        batch_start = 1'b0;
  logic [5:0]  batch_len = '0;
  logic        procc_done = 1'b0;
  logic [31:0] res_procc0 = '0, res_extra0 = '0, res_procc1 = '0, res_extra1 = '0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        batch_busy, batch_done, overflow, stray;

  int checks = 0;
  int errors = 0;

  simd_result_collector #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .reset(reset), .batch_start(batch_start), .batch_len(batch_len),
    .procc_done(procc_done), .res_procc0(res_procc0), .res_extra0(res_extra0),
    .res_procc1(res_procc1), .res_extra1(res_extra1), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .batch_busy(batch_busy),
    .batch_done(batch_done), .overflow(overflow), .stray(stray)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] p0, p1, e0, e1;
    logic [63:0] exp0, exp1;
  } rec_t;

  rec_t vec [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_k(input int k, input int half);
    if (half == 0)
      return {32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k)};
    else
      return {32'hC000_0000 | 32'(k), 32'hD000_0000 | 32'(k)};
  endfunction

  task automatic set_data(input int k);
    res_procc0 = 32'hA000_0000 | 32'(k);
    res_procc1 = 32'hB000_0000 | 32'(k);
    res_extra0 = 32'hC000_0000 | 32'(k);
    res_extra1 = 32'hD000_0000 | 32'(k);
  endtask

  // Called on a negedge; leaves procc_done low long enough for the next rising edge.
  task automatic capture(input int k);
    set_data(k);
    procc_done = 1'b1;
    @(negedge clk);
    procc_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [5:0] len);
    @(negedge clk);
    batch_start = 1'b1;
    batch_len   = len;
    @(negedge clk);
    batch_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int n, input int base);
    rd_ready = 1'b1;
    for (int b = 0; b < n * BEATS; b++) begin
      chk1("drain_valid", rd_valid, 1'b1);
      chk64("drain_data", rd_data, exp_k(base + b / BEATS, b % BEATS));
      $display("beat %0d entry %0d data %h", b, base + b / BEATS, rd_data);
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk1("drain_empty", rd_valid, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (batch_done) begin
        n++;
        chk1({tag, "_done_fifo_empty"}, rd_valid, 1'b0);
      end
    end
    chk64({tag, "_done_pulses"}, 64'(n), 64'd1);
    chk1({tag, "_idle_after"}, batch_busy, 1'b0);
  endtask

  initial begin
    vec[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
               64'h00000001_00000002, 64'h00000003_00000004};
    vec[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0,
               64'hFFFFFFFF_00000000, 64'h12345678_9ABCDEF0};
    vec[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hCAFE_BABE,
               64'h00000000_FFFFFFFF, 64'hDEADBEEF_CAFEBABE};
    vec[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000,
               64'h80000000_7FFFFFFF, 64'h00000000_00000000};
    vec[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0001, 32'hFFFF_FFFF,
               64'hA5A5A5A5_5A5A5A5A, 64'h00000001_FFFFFFFF};

    // Reset state
    do_reset();
    chk1("rst_valid", rd_valid, 1'b0);
    chk1("rst_busy", batch_busy, 1'b0);
    chk1("rst_done", batch_done, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_stray", stray, 1'b0);
    chk64("rst_data", rd_data, 64'd0);

    // len=1 with rd_ready high: data visible the cycle after capture
    start(6'd1);
    chk1("t1_busy", batch_busy, 1'b1);
    rd_ready   = 1'b1;
    res_procc0 = 32'd1; res_procc1 = 32'd2; res_extra0 = 32'd3; res_extra1 = 32'd4;
    procc_done = 1'b1;
    @(negedge clk);
    procc_done = 1'b0;
    chk1("t1_valid", rd_valid, 1'b1);
    chk64("t1_beat0", rd_data, 64'h00000001_00000002);
    if (BEATS == 2) begin
      @(negedge clk);
      chk64("t1_beat1", rd_data, 64'h00000003_00000004);
    end
    wait_done("t1");
    rd_ready = 1'b0;

    // Table vectors: five captures buffered, then drained in order
    start(6'd5);
    for (int i = 0; i < 5; i++) begin
      res_procc0 = vec[i].p0; res_procc1 = vec[i].p1;
      res_extra0 = vec[i].e0; res_extra1 = vec[i].e1;
      procc_done = 1'b1;
      @(negedge clk);
      procc_done = 1'b0;
      @(negedge clk);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk64("tab_beat0", rd_data, vec[i].exp0);
      $display("vec %0d beat0 %h", i, rd_data);
      @(negedge clk);
      if (BEATS == 2) begin
        chk64("tab_beat1", rd_data, vec[i].exp1);
        $display("vec %0d beat1 %h", i, rd_data);
        @(negedge clk);
      end
    end
    rd_ready = 1'b0;
    wait_done("tab");

    // Overflow: len=DEPTH+1 with no reader, ninth capture dropped
    start(6'(DEPTH + 1));
    for (int k = 1; k <= DEPTH; k++) capture(k);
    chk1("t2_no_overflow_yet", overflow, 1'b0);
    capture(DEPTH + 1);
    chk1("t2_overflow", overflow, 1'b1);
    chk1("t2_busy", batch_busy, 1'b1);
    drain(DEPTH, 1);
    chk1("t2_still_collect", batch_busy, 1'b1);
    chk1("t2_no_early_done", batch_done, 1'b0);
    capture(DEPTH + 2);
    drain(1, DEPTH + 2);
    wait_done("t2");

    // Full FIFO, head popped on the same edge as a capture
    start(6'(DEPTH + 2));
    chk1("t3_overflow_cleared", overflow, 1'b0);
    for (int k = 1; k <= DEPTH; k++) capture(k);
    if (BEATS == 2) begin
      rd_ready = 1'b1;
      @(negedge clk);
    end
    set_data(DEPTH + 1);
    rd_ready   = 1'b1;
    procc_done = 1'b1;
    @(negedge clk);
    procc_done = 1'b0;
    rd_ready   = 1'b0;
    @(negedge clk);
    chk1("t3_overflow", overflow, 1'b0);
    drain(DEPTH, 2);
    capture(DEPTH + 2);
    drain(1, DEPTH + 2);
    wait_done("t3");

    // Random back-pressure over 20 captures with pointer wrap
    start(6'd20);
    fork
      begin
        for (int k = 1; k <= 20; k++) begin
          repeat (2) @(negedge clk);
          capture(k);
        end
      end
      begin
        int idx = 0;
        int cyc = 0;
        while (idx < 20 * BEATS && cyc < 1000) begin
          @(negedge clk);
          cyc++;
          if (rd_valid) chk64("t4_data", rd_data, exp_k(1 + idx / BEATS, idx % BEATS));
          rd_ready = ($urandom_range(3) != 0);
          if (rd_valid && rd_ready) begin
            $display("stream beat %0d data %h", idx, rd_data);
            idx++;
          end
        end
        @(negedge clk);
        rd_ready = 1'b0;
        chk64("t4_beats_received", 64'(idx), 64'(20 * BEATS));
      end
    join
    chk1("t4_overflow", overflow, 1'b0);
    wait_done("t4");

    // procc_done held high: one capture only
    start(6'd2);
    set_data(1);
    procc_done = 1'b1;
    repeat (5) @(negedge clk);
    procc_done = 1'b0;
    @(negedge clk);
    drain(1, 1);
    chk1("t5_still_collect", batch_busy, 1'b1);
    capture(2);
    drain(1, 2);
    wait_done("t5");
    chk1("t5_stray_clear", stray, 1'b0);
    capture(3);
    chk1("t5_stray", stray, 1'b1);
    chk1("t5_nothing_stored", rd_valid, 1'b0);

    // len=0: batch_done two cycles after batch_start; start clears stray
    @(negedge clk);
    batch_start = 1'b1;
    batch_len   = 6'd0;
    @(negedge clk);
    batch_start = 1'b0;
    chk1("t6_stray_cleared", stray, 1'b0);
    chk1("t6_busy", batch_busy, 1'b1);
    chk1("t6_done_early", batch_done, 1'b0);
    @(negedge clk);
    chk1("t6_done", batch_done, 1'b1);
    @(negedge clk);
    chk1("t6_done_one_cycle", batch_done, 1'b0);
    chk1("t6_idle", batch_busy, 1'b0);

    // Asynchronous reset in the middle of COLLECT
    start(6'd3);
    capture(1);
    chk1("t7_valid_before", rd_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("t7_valid_rst", rd_valid, 1'b0);
    chk1("t7_busy_rst", batch_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int n = 0;
      repeat (10) begin
        @(negedge clk);
        if (batch_done) n++;
      end
      chk64("t7_no_done", 64'(n), 64'd0);
    end
    chk1("t7_valid_after", rd_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
